// File: rtl/instruction_fetch_unit.sv
// RV32 instruction fetch stage: PC register, busywait memory handshake and IF/ID register.
// Branch redirects flush IF/ID; a fetch already in flight is drained before redirecting.
module instruction_fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        STALL,
   input  logic        BRANCH_TAKEN,
   input  logic [31:0] BRANCH_TARGET,
   output logic        IMEM_READ,
   output logic [31:0] IMEM_ADDRESS,
   input  logic [31:0] IMEM_READDATA,
   input  logic        IMEM_BUSYWAIT,
   output logic [31:0] INSTRUCTION,
   output logic [31:0] PC_OUT,
   output logic        VALID
);

   typedef enum logic [1:0] {
      S_FETCH   = 2'd0,
      S_HOLD    = 2'd1,
      S_DISCARD = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_state_next;
   logic [31:0] r_pc;
   logic [31:0] r_instr;
   logic [31:0] r_pc_out;
   logic        r_valid;
   logic [31:0] r_buf_instr;
   logic [31:0] r_buf_pc;
   logic [31:0] r_target;

   logic        w_done;
   logic [31:0] w_target;
   logic [31:0] w_pc_inc;

   assign w_done   = IMEM_READ & ~IMEM_BUSYWAIT;
   assign w_target = BRANCH_TARGET & ~32'h0000_0003;
   assign w_pc_inc = r_pc + 32'd4;

   assign IMEM_ADDRESS = r_pc;
   assign INSTRUCTION  = r_instr;
   assign PC_OUT       = r_pc_out;
   assign VALID        = r_valid;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) r_state <= S_FETCH;
      else       r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_FETCH: begin
            if (BRANCH_TAKEN) begin
               if (!w_done) w_state_next = S_DISCARD;
            end else if (w_done && STALL) begin
               w_state_next = S_HOLD;
            end
         end
         S_HOLD: begin
            if (BRANCH_TAKEN || !STALL) w_state_next = S_FETCH;
         end
         S_DISCARD: begin
            if (w_done) w_state_next = S_FETCH;
         end
         default: w_state_next = S_FETCH;
      endcase
   end

   always_comb begin
      IMEM_READ = 1'b1;
      if (r_state == S_HOLD) IMEM_READ = 1'b0;
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_pc        <= RESET_PC;
         r_instr     <= NOP_INSTR;
         r_pc_out    <= 32'd0;
         r_valid     <= 1'b0;
         r_buf_instr <= 32'd0;
         r_buf_pc    <= 32'd0;
         r_target    <= 32'd0;
      end else begin
         case (r_state)
            S_FETCH: begin
               if (w_done) begin
                  if (BRANCH_TAKEN) begin
                     r_pc    <= w_target;
                     r_instr <= NOP_INSTR;
                     r_valid <= 1'b0;
                  end else if (!STALL) begin
                     r_instr  <= IMEM_READDATA;
                     r_pc_out <= r_pc;
                     r_valid  <= 1'b1;
                     r_pc     <= w_pc_inc;
                  end else begin
                     r_buf_instr <= IMEM_READDATA;
                     r_buf_pc    <= r_pc;
                     r_pc        <= w_pc_inc;
                  end
               end else if (BRANCH_TAKEN) begin
                  r_target <= w_target;
                  r_instr  <= NOP_INSTR;
                  r_valid  <= 1'b0;
               end else if (!STALL) begin
                  r_instr <= NOP_INSTR;
                  r_valid <= 1'b0;
               end
            end
            S_HOLD: begin
               if (BRANCH_TAKEN) begin
                  r_pc    <= w_target;
                  r_instr <= NOP_INSTR;
                  r_valid <= 1'b0;
               end else if (!STALL) begin
                  r_instr  <= r_buf_instr;
                  r_pc_out <= r_buf_pc;
                  r_valid  <= 1'b1;
               end
            end
            S_DISCARD: begin
               // A newer redirect arriving on the completion edge wins over the saved one.
               if (BRANCH_TAKEN) r_target <= w_target;
               if (w_done) r_pc <= BRANCH_TAKEN ? w_target : r_target;
               if (BRANCH_TAKEN || !STALL) begin
                  r_instr <= NOP_INSTR;
                  r_valid <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Testbench for instruction_fetch_unit: directed vector table, reset corner case,
// and randomized traffic checked against a transaction-level reference model.
module tb_instruction_fetch_unit;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        CLK = 1'b0;
   logic        RESET;
   logic        STALL;
   logic        BRANCH_TAKEN;
   logic [31:0] BRANCH_TARGET;
   logic        IMEM_READ;
   logic [31:0] IMEM_ADDRESS;
   logic [31:0] IMEM_READDATA;
   logic        IMEM_BUSYWAIT;
   logic [31:0] INSTRUCTION;
   logic [31:0] PC_OUT;
   logic        VALID;
   logic [31:0] mem_xor;

   int checks = 0;
   int errors = 0;

   instruction_fetch_unit dut (
      .CLK           (CLK),
      .RESET         (RESET),
      .STALL         (STALL),
      .BRANCH_TAKEN  (BRANCH_TAKEN),
      .BRANCH_TARGET (BRANCH_TARGET),
      .IMEM_READ     (IMEM_READ),
      .IMEM_ADDRESS  (IMEM_ADDRESS),
      .IMEM_READDATA (IMEM_READDATA),
      .IMEM_BUSYWAIT (IMEM_BUSYWAIT),
      .INSTRUCTION   (INSTRUCTION),
      .PC_OUT        (PC_OUT),
      .VALID         (VALID)
   );

   always #5 CLK = ~CLK;

   // Memory returns a word derived from its address.
   assign IMEM_READDATA = IMEM_ADDRESS ^ mem_xor;

   typedef struct {
      logic        stall;
      logic        br;
      logic        busy;
      logic [31:0] tgt;
      logic [31:0] e_addr;
      logic        e_read;
      logic [31:0] e_instr;
      logic [31:0] e_pcout;
      logic        e_valid;
   } vec_t;

   vec_t vq[$];

   function automatic void add(logic s, logic b, logic w, logic [31:0] t,
                               logic [31:0] a, logic r, logic [31:0] i,
                               logic [31:0] p, logic v);
      vec_t x;
      x.stall = s; x.br = b; x.busy = w; x.tgt = t;
      x.e_addr = a; x.e_read = r; x.e_instr = i; x.e_pcout = p; x.e_valid = v;
      vq.push_back(x);
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_all(string tag, logic [31:0] a, logic r, logic [31:0] i,
                            logic [31:0] p, logic v);
      check({tag, ".addr"},  IMEM_ADDRESS, a);
      check({tag, ".read"},  {31'd0, IMEM_READ}, {31'd0, r});
      check({tag, ".instr"}, INSTRUCTION, i);
      check({tag, ".pcout"}, PC_OUT, p);
      check({tag, ".valid"}, {31'd0, VALID}, {31'd0, v});
   endtask

   task automatic drive(logic s, logic b, logic w, logic [31:0] t);
      STALL = s; BRANCH_TAKEN = b; IMEM_BUSYWAIT = w; BRANCH_TARGET = t;
   endtask

   // Reference model: the stage as a program counter, a one-deep queue of
   // words fetched while decode was stalled, and an optional pending redirect.
   typedef struct { logic [31:0] data; logic [31:0] pc; } word_t;
   word_t       m_q[$];
   logic [31:0] m_pc, m_instr, m_pcout, m_redir;
   logic        m_valid, m_redir_v;

   function automatic void model_reset();
      m_q.delete();
      m_pc = 32'd0; m_instr = NOP; m_pcout = 32'd0; m_valid = 1'b0;
      m_redir_v = 1'b0; m_redir = 32'd0;
   endfunction

   function automatic void model_step(logic stall, logic br, logic [31:0] tgt_raw,
                                      logic busy, logic [31:0] xr);
      logic [31:0] tgt;
      logic        requesting;
      logic        got;
      logic        bubble;
      word_t       w;
      tgt        = {tgt_raw[31:2], 2'b00};
      requesting = (m_q.size() == 0);
      got        = requesting && !busy;
      bubble     = 1'b0;
      if (m_q.size() != 0) begin
         if (br) begin
            m_q.delete(); m_pc = tgt; bubble = 1'b1;
         end else if (!stall) begin
            w = m_q.pop_front();
            m_instr = w.data; m_pcout = w.pc; m_valid = 1'b1;
         end
      end else if (m_redir_v) begin
         if (br) m_redir = tgt;
         if (got) begin m_pc = m_redir; m_redir_v = 1'b0; end
         if (br || !stall) bubble = 1'b1;
      end else if (got) begin
         if (br) begin
            m_pc = tgt; bubble = 1'b1;
         end else if (!stall) begin
            m_instr = m_pc ^ xr; m_pcout = m_pc; m_valid = 1'b1; m_pc = m_pc + 32'd4;
         end else begin
            w.data = m_pc ^ xr; w.pc = m_pc; m_q.push_back(w); m_pc = m_pc + 32'd4;
         end
      end else if (br) begin
         m_redir_v = 1'b1; m_redir = tgt; bubble = 1'b1;
      end else if (!stall) begin
         bubble = 1'b1;
      end
      if (bubble) begin m_instr = NOP; m_valid = 1'b0; end
   endfunction

   initial begin
      mem_xor = 32'd0;
      RESET = 1'b1;
      drive(0, 0, 0, 32'd0);

      add(0,0,0,32'h0,        32'h4,1,32'h0,32'h0,1);
      add(0,0,0,32'h0,        32'h8,1,32'h4,32'h4,1);
      add(0,0,1,32'h0,        32'h8,1,NOP,32'h4,0);
      add(0,0,1,32'h0,        32'h8,1,NOP,32'h4,0);
      add(0,0,1,32'h0,        32'h8,1,NOP,32'h4,0);
      add(0,0,0,32'h0,        32'hC,1,32'h8,32'h8,1);
      add(0,0,0,32'h0,        32'h10,1,32'hC,32'hC,1);
      add(1,0,0,32'h0,        32'h14,0,32'hC,32'hC,1);
      add(1,0,0,32'h0,        32'h14,0,32'hC,32'hC,1);
      add(0,0,0,32'h0,        32'h14,1,32'h10,32'h10,1);
      add(0,0,0,32'h0,        32'h18,1,32'h14,32'h14,1);
      add(0,0,0,32'h0,        32'h1C,1,32'h18,32'h18,1);
      add(0,0,0,32'h0,        32'h20,1,32'h1C,32'h1C,1);
      add(0,1,0,32'h100,      32'h100,1,NOP,32'h1C,0);
      add(0,0,0,32'h0,        32'h104,1,32'h100,32'h100,1);
      add(0,1,0,32'h40,       32'h40,1,NOP,32'h100,0);
      add(0,1,1,32'h203,      32'h40,1,NOP,32'h100,0);
      add(0,0,1,32'h0,        32'h40,1,NOP,32'h100,0);
      add(0,0,0,32'h0,        32'h200,1,NOP,32'h100,0);
      add(0,0,0,32'h0,        32'h204,1,32'h200,32'h200,1);
      add(0,1,0,32'hFFFF_FFFC,32'hFFFF_FFFC,1,NOP,32'h200,0);
      add(0,0,0,32'h0,        32'h0,1,32'hFFFF_FFFC,32'hFFFF_FFFC,1);
      add(0,0,0,32'h0,        32'h4,1,32'h0,32'h0,1);
      add(1,0,1,32'h0,        32'h4,1,32'h0,32'h0,1);
      add(1,1,1,32'h300,      32'h4,1,NOP,32'h0,0);
      add(1,0,0,32'h0,        32'h300,1,NOP,32'h0,0);
      add(0,0,0,32'h0,        32'h304,1,32'h300,32'h300,1);
      add(1,0,0,32'h0,        32'h308,0,32'h300,32'h300,1);
      add(1,1,0,32'h400,      32'h400,1,NOP,32'h300,0);
      add(0,0,0,32'h0,        32'h404,1,32'h400,32'h400,1);

      #11;
      check_all("reset", 32'h0, 1'b1, NOP, 32'h0, 1'b0);
      #1 RESET = 1'b0;

      for (int i = 0; i < vq.size(); i++) begin
         drive(vq[i].stall, vq[i].br, vq[i].busy, vq[i].tgt);
         @(posedge CLK); #1;
         check_all($sformatf("vec%0d", i), vq[i].e_addr, vq[i].e_read,
                   vq[i].e_instr, vq[i].e_pcout, vq[i].e_valid);
      end

      // Reset in the middle of a drained redirect at the top of memory.
      drive(0, 1, 0, 32'hFFFF_FFFC);
      @(posedge CLK); #1;
      drive(0, 1, 1, 32'h500);
      @(posedge CLK); #1;
      check("disc.addr", IMEM_ADDRESS, 32'hFFFF_FFFC);
      drive(0, 0, 1, 32'h0);
      #3 RESET = 1'b1;
      #1;
      check_all("async_rst", 32'h0, 1'b1, NOP, 32'h0, 1'b0);
      #1 RESET = 1'b0;
      drive(0, 0, 0, 32'h0);
      @(posedge CLK); #1;
      check_all("post_rst", 32'h4, 1'b1, 32'h0, 32'h0, 1'b1);

      // Randomized traffic against the reference model.
      mem_xor = 32'h5A5A_1234;
      #2 RESET = 1'b1;
      #1 RESET = 1'b0;
      model_reset();
      for (int n = 0; n < 3000; n++) begin
         logic s, b, w;
         logic [31:0] t;
         s = ($urandom % 4) == 0;
         b = ($urandom % 8) == 0;
         w = ($urandom % 3) == 0;
         t = (($urandom % 4) == 0) ? (32'hFFFF_FFF0 | ($urandom % 16)) : $urandom;
         drive(s, b, w, t);
         model_step(s, b, t, w, mem_xor);
         @(posedge CLK); #1;
         check_all("rand", m_pc, (m_q.size() == 0), m_instr, m_pcout, m_valid);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
